// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states
// and the byte-count helper used by the alignment logic.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_CAPT,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load extract/extend and store merge for a big-endian
// doubleword whose addressed byte sits in bits [63:56].
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_rd,
  input  logic [63:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_ldata,
  output logic [63:0] o_merged
);

  logic [6:0]  w_lo_bits;
  logic [63:0] w_hi_mask;
  logic [63:0] w_lo_mask;
  logic        w_sign;

  // w_lo_bits is the count of doubleword bits not covered by the access
  assign w_lo_bits = 7'd64 - {size_bytes(i_size), 3'b000};
  assign w_hi_mask = ~64'd0 << w_lo_bits;
  assign w_lo_mask = ~64'd0 >> w_lo_bits;

  // The field's sign bit is always bit 63 since the field is top-aligned
  assign w_sign   = ~i_unsigned & i_rd[63];
  assign o_ldata  = (i_rd >> w_lo_bits) | (w_sign ? ~w_lo_mask : 64'd0);
  assign o_merged = ((i_wdata << w_lo_bits) & w_hi_mask) | (i_rd & ~w_hi_mask);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: single outstanding request, read-modify-write for
// sub-doubleword stores, extended load data, one response per request.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data
);

  state_e      r_state;
  state_e      w_next;
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wr_data;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        w_accept;
  logic        w_oor;
  logic [63:0] w_ldata;
  logic [63:0] w_merged;

  assign w_oor     = |req_addr[63:MEM_AW];
  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_oor)                            w_next = ST_RESP;
          else if (req_store && req_size == SZ_D) w_next = ST_WRITE;
          else                                  w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_store ? ST_MERGE : ST_CAPT;
      ST_MERGE: w_next = ST_WRITE;
      ST_CAPT:  w_next = ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  if (resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request latch at acceptance; merge and capture reuse the same registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_store    <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_addr     <= 64'd0;
      r_wr_data  <= 64'd0;
      r_rdata    <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_store    <= req_store;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wr_data  <= req_wdata;
            r_rdata    <= 64'd0;
            r_err      <= w_oor;
          end
        end
        ST_MERGE: r_wr_data <= w_merged;
        ST_CAPT:  r_rdata   <= w_ldata;
        default:  ;
      endcase
    end
  end

  lsu_align u_align (
    .i_rd       (mem_read_data),
    .i_wdata    (r_wr_data),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ldata    (w_ldata),
    .o_merged   (w_merged)
  );

  assign mem_read       = (r_state == ST_READ);
  assign mem_write      = (r_state == ST_WRITE);
  assign mem_address    = r_addr;
  assign mem_write_data = r_wr_data;
  assign resp_valid     = (r_state == ST_RESP);
  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that sits between the pipeline's memory stage and the 64-bit byte-addressed data memory, acting as the sole initiator on that memory's MemRead/MemWrite port. It accepts one load or store request at a time. It performs sub-doubleword stores (sb/sh/sw) as read-modify-write sequences over the doubleword-only memory port. It sign- or zero-extends sub-doubleword loads and returns one response per request.

## Interface
Parameters:
- MEM_AW, 10: memory address width in bits. Addresses with any bit set at [63:MEM_AW] are out of range.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high; shared with the data memory.
- req_valid, in, 1: request present.
- req_ready, out, 1: controller can accept a request; high only in IDLE.
- req_store, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 00 byte, 01 half, 10 word, 11 double.
- req_unsigned, in, 1: zero-extend the load result; ignored for stores and for double.
- req_addr, in, 64: byte address.
- req_wdata, in, 64: store data, right-justified (a byte store uses bits [7:0]).
- resp_valid, out, 1: response present.
- resp_ready, in, 1: consumer takes the response.
- resp_rdata, out, 64: extended load data; 0 for stores and faults.
- resp_err, out, 1: out-of-range address.
- mem_address, out, 64: to memory `address`.
- mem_write_data, out, 64: to memory `write_data`.
- mem_read, out, 1: to `MemRead`.
- mem_write, out, 1: to `MemWrite`.
- mem_read_data, in, 64: from `read_data`; valid in the cycle after `mem_read` is high.

## Operation
- **Memory model.** The memory is big-endian. The doubleword read or written at A holds byte A in bits [63:56] and byte A+7 in bits [7:0]. Byte offsets wrap modulo 2^MEM_AW.
- **Request latch.** A request is accepted when `req_valid && req_ready`. All request fields are latched at acceptance; inputs are ignored afterwards.
- **States:** IDLE, READ, MERGE, CAPT, WRITE, RESP.
- **Range check.** At acceptance, if `req_addr[63:MEM_AW] != 0`, go IDLE→RESP with `resp_err=1` and `resp_rdata=0`. No memory strobe is issued.
- **Load path:** IDLE→READ→CAPT→RESP.
  - READ: `mem_read=1`, `mem_address` = latched address.
  - CAPT: register the extended result from `mem_read_data`:
    - byte: [63:56]
    - half: [63:48]
    - word: [63:32]
    - double: all 64 bits
  - Sign-extend unless `req_unsigned` is set.
- **sd path:** IDLE→WRITE→RESP. WRITE: `mem_write=1`, `mem_write_data = req_wdata`.
- **sb/sh/sw path:** IDLE→READ→MERGE→WRITE→RESP. MERGE registers the write-back doubleword; WRITE writes it back to the same address.
  - sb: {wdata[7:0], rd[55:0]}
  - sh: {wdata[15:0], rd[47:0]}
  - sw: {wdata[31:0], rd[31:0]}
- **RESP.** `resp_valid=1`; all response fields stay stable until `resp_ready`. On `resp_ready`, go to IDLE.
- **Strobes.** `mem_read` and `mem_write` are never high together, and are never high outside READ and WRITE respectively.

## Timing
- Accept occurs in cycle 0. The first cycle with `resp_valid` is:
  - fault: 1
  - sd: 2
  - load: 3
  - sb/sh/sw: 4
- Back-to-back: `resp_ready` in cycle N means IDLE in N+1, so the next accept is possible in N+1.
- Read-after-store: a load accepted after a store's response observes the stored data, because the write commits at the end of the WRITE cycle.
- Wrap: a word store at 1020 rewrites bytes 1020..1023 with new data and bytes 0..3 with their unchanged read-back values.
- **Reset values:**
  - state = IDLE
  - `req_ready = 1` (from the first cycle after reset)
  - `resp_valid = 0`, `resp_err = 0`
  - `resp_rdata = 0`
  - `mem_read = 0`, `mem_write = 0`
  - `mem_address = 0`, `mem_write_data = 0`
- **Reset mid-operation.** The operation is abandoned and no response is produced. A reset sampled during WRITE performs no write, because the memory is reset in the same cycle.

## Structure
- Package `lsu_pkg` holds:
  - the size encodings SZ_B, SZ_H, SZ_W, SZ_D
  - the state enum
  - the function `size_bytes(size)`
- Sub-module `lsu_align` is purely combinational and contains:
  - the load extract/extend: `(rd, size, unsigned) → data`
  - the store merge: `(rd, wdata, size) → doubleword`
- `lsu_ctrl` contains only the FSM, the request/response registers, and the memory port drive.

## Test plan
- **sd then ld.** sd 0x0123456789ABCDEF @8, then ld @8 → `resp_rdata = 0x0123456789ABCDEF`. sd response in cycle 2, ld response in cycle 3.
- **Byte and half loads.** After the sd above:
  - lb @8 → 0x0000000000000001
  - lbu @15 → 0x00000000000000EF
  - lb @15 → 0xFFFFFFFFFFFFFFEF
  - lh @14 → 0xFFFFFFFFFFFFCDEF
- **Sub-word stores.** After the sd above:
  - sb 0xAA @9 (mem_write in cycle 3, resp in cycle 4), then ld @8 → 0x01AA456789ABCDEF
  - sw 0xDEADBEEF @12, then ld @8 → 0x01AA4567DEADBEEF
- **Range fault.** ld @0x400 → `resp_err=1`, `resp_rdata=0`, resp in cycle 1, no `mem_read`/`mem_write` pulse.
- **Back-pressure.** Hold `resp_ready=0` for 5 cycles → `resp_valid`/`resp_rdata` stable and `req_ready=0` throughout. Release → next request accepted in the following cycle.
- **Reset mid-operation.** Reset asserted in the MERGE cycle of sb 0x55 @16 → no `mem_write`, no response; then ld @16 → unchanged prior value, `req_ready=1` after reset.
